waveform_stream_sched: RTL

Controller that sequences the waveform_stream BRAM buffer. It loads one waveform: a parameter latch, the init_wf_write/wf_write_ready handshake, then a count of input beats to tlast. It then plays the stored waveform out as a burst of N pulses at a programmable pulse-repetition interval (PRI) by gating the consumer's tready. It sits between the host command registers and waveform_stream, on the DAC-side fmc_tclk domain.

---
 rtl/waveform_stream_sched.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/waveform_stream_sched.sv
// Purpose: sequences the waveform_stream buffer: latches and loads one waveform, then plays it as a pulse burst at a fixed PRI.
// Latency: each command is accepted on the clock after its pulse, and every output is a register.
// Backpressure: the load stream is only counted while it handshakes, and playback is paced by gating the consumer's tready.
module waveform_stream_sched #(
    parameter int LEN_W = 16,
    parameter int PRI_W = 32,
    parameter int NP_W  = 16
) (
    input  logic             clk_in1,
    input  logic             areset,
    input  logic             cmd_load,
    input  logic             cmd_run,
    input  logic             cmd_abort,
    input  logic [LEN_W-1:0] cmd_wf_len,
    input  logic [NP_W-1:0]  cmd_num_pulses,
    input  logic [PRI_W-1:0] cmd_pri,
    output logic [127:0]     waveform_parameters,
    output logic             init_wf_write,
    input  logic             wf_write_ready,
    input  logic             wf_read_ready,
    input  logic             wfin_tvalid,
    input  logic             wfin_tready,
    input  logic             wfin_tlast,
    input  logic             wfout_tvalid,
    input  logic             wfout_tlast,
    output logic             wfout_gate,
    output logic             pulse_start,
    output logic             loaded,
    output logic             busy,
    output logic             done,
    output logic             err_len,
    output logic             err_overrun,
    output logic             err_param
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        PLAY_WAIT,
        PULSE,
        GAP
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
    localparam logic [NP_W-1:0]  NP_ONE  = {{(NP_W-1){1'b0}}, 1'b1};
    localparam logic [PRI_W-1:0] PRI_ONE = {{(PRI_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [LEN_W-1:0] beat_cnt;
    logic [NP_W-1:0]  num_pulses;
    logic [NP_W-1:0]  pulses_done;
    logic [PRI_W-1:0] pri;
    logic [PRI_W-1:0] pri_cnt;

    logic             in_beat;
    logic             out_last;
    logic [LEN_W-1:0] beat_next;
    logic [NP_W-1:0]  pulses_next;
    logic [PRI_W-1:0] pri_dec;

    // Handshake qualifiers and saturating next values shared by the FSM.
    assign in_beat     = wfin_tvalid & wfin_tready;
    assign out_last    = wfout_tvalid & wfout_gate & wfout_tlast;
    assign beat_next   = (beat_cnt == LEN_MAX) ? LEN_MAX : beat_cnt + LEN_ONE;
    assign pulses_next = pulses_done + NP_ONE;
    assign pri_dec     = (pri_cnt == '0) ? '0 : pri_cnt - PRI_ONE;

    // Load/playback state machine with all outputs registered.
    always_ff @(posedge clk_in1 or posedge areset) begin
        if (areset) begin
            state               <= IDLE;
            waveform_parameters <= '0;
            init_wf_write       <= 1'b0;
            wfout_gate          <= 1'b0;
            pulse_start         <= 1'b0;
            loaded              <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            err_len             <= 1'b0;
            err_overrun         <= 1'b0;
            err_param           <= 1'b0;
            beat_cnt            <= '0;
            num_pulses          <= '0;
            pulses_done         <= '0;
            pri                 <= '0;
            pri_cnt             <= '0;
        end else begin
            pulse_start <= 1'b0;
            done        <= 1'b0;
            if (cmd_abort && state != IDLE) begin
                // Abort wins over everything else outside IDLE; a partial load leaves no valid waveform.
                state         <= IDLE;
                init_wf_write <= 1'b0;
                wfout_gate    <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b1;
                if (state == REQ || state == LOAD) begin
                    loaded <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_load) begin
                            if (cmd_wf_len == '0) begin
                                err_param <= 1'b1;
                            end else begin
                                waveform_parameters <= {{(128-LEN_W){1'b0}}, cmd_wf_len};
                                loaded              <= 1'b0;
                                init_wf_write       <= 1'b1;
                                busy                <= 1'b1;
                                state               <= REQ;
                            end
                        end else if (cmd_run) begin
                            if (!loaded || cmd_pri == '0) begin
                                err_param <= 1'b1;
                            end else if (cmd_num_pulses == '0) begin
                                done <= 1'b1;
                            end else begin
                                num_pulses  <= cmd_num_pulses;
                                pri         <= cmd_pri;
                                pulses_done <= '0;
                                busy        <= 1'b1;
                                state       <= PLAY_WAIT;
                            end
                        end
                    end
                    REQ: begin
                        if (wf_write_ready) begin
                            init_wf_write <= 1'b0;
                            beat_cnt      <= '0;
                            state         <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (in_beat) begin
                            beat_cnt <= beat_next;
                            if (wfin_tlast) begin
                                if (beat_next != waveform_parameters[LEN_W-1:0]) begin
                                    err_len <= 1'b1;
                                end
                                loaded <= 1'b1;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                                state  <= IDLE;
                            end else if (beat_cnt == LEN_MAX) begin
                                // Counter is pinned; the stream is already longer than any legal length.
                                err_len <= 1'b1;
                            end
                        end
                    end
                    PLAY_WAIT: begin
                        if (wf_read_ready) begin
                            pri_cnt     <= pri - PRI_ONE;
                            pulse_start <= 1'b1;
                            wfout_gate  <= 1'b1;
                            state       <= PULSE;
                        end
                    end
                    PULSE: begin
                        pri_cnt <= pri_dec;
                        // PRI ran out while the pulse was still streaming.
                        if (pri_cnt == '0) begin
                            err_overrun <= 1'b1;
                        end
                        if (out_last) begin
                            wfout_gate  <= 1'b0;
                            pulses_done <= pulses_next;
                            if (pulses_next == num_pulses) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end
                    GAP: begin
                        // The counter keeps running through the gap so starts stay exactly one PRI apart.
                        if (pri_cnt == '0) begin
                            pri_cnt     <= pri - PRI_ONE;
                            pulse_start <= 1'b1;
                            wfout_gate  <= 1'b1;
                            state       <= PULSE;
                        end else begin
                            pri_cnt <= pri_dec;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
